// File: rtl/det_window_counter.sv
// rtl/det_window_counter.sv - windowed detection-event counter with valid/ready result port (edge mode: DET_WINDOW_EDGE_EN)
module det_window_counter #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             sat,
    output logic             dropped
);

    localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TW-1:0]    LAST    = TW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             acc_sat_q, acc_sat_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             sat_q, sat_d;
    logic             dropped_q, dropped_d;

    logic             event_w;
    logic [CNT_W-1:0] fin_acc;
    logic             fin_sat;
    logic             close_w;
    logic             handshake_w;

`ifdef DET_WINDOW_EDGE_EN
    logic det_q;

    // Previous det level, tracked in every state so a level held across en rising is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            det_q <= 1'b0;
        end else begin
            det_q <= det;
        end
    end

    assign event_w = det & ~det_q;
`else
    assign event_w = det;
`endif

    // Saturating accumulator value including this cycle's event
    always_comb begin
        fin_acc = acc_q;
        fin_sat = acc_sat_q;
        if (event_w) begin
            if (acc_q == ACC_MAX) begin
                fin_sat = 1'b1;
            end else begin
                fin_acc = acc_q + 1'b1;
            end
        end
    end

    assign handshake_w = valid_q & count_ready;

    // Next-state: window FSM, timer/accumulator and result register with drop tracking
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        acc_d     = acc_q;
        acc_sat_d = acc_sat_q;
        count_d   = count_q;
        valid_d   = valid_q;
        sat_d     = sat_q;
        dropped_d = dropped_q;
        close_w   = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d   = '0;
                acc_d     = '0;
                acc_sat_d = 1'b0;
                if (en) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!en) begin
                    // Partial window is abandoned, nothing is reported for it
                    state_d   = IDLE;
                    timer_d   = '0;
                    acc_d     = '0;
                    acc_sat_d = 1'b0;
                end else if (timer_q == LAST) begin
                    close_w   = 1'b1;
                    timer_d   = '0;
                    acc_d     = '0;
                    acc_sat_d = 1'b0;
                end else begin
                    timer_d   = timer_q + 1'b1;
                    acc_d     = fin_acc;
                    acc_sat_d = fin_sat;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (handshake_w) begin
            valid_d = 1'b0;
        end

        if (close_w) begin
            // A result consumed on this edge frees the register for the new one
            if (!valid_q || handshake_w) begin
                count_d = fin_acc;
                sat_d   = fin_sat;
                valid_d = 1'b1;
            end else begin
                dropped_d = 1'b1;
            end
        end
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            sat_q     <= sat_d;
            dropped_q <= dropped_d;
        end
    end

    assign count       = count_q;
    assign count_valid = valid_q;
    assign sat         = sat_q;
    assign dropped     = dropped_q;

endmodule
